data_sram_resp: RTL
===================

# data_sram_resp

Data-side synchronous SRAM responder for the five-stage pipeline: the memory end of the data SRAM port the EX stage drives and the MEM stage reads. It accepts the CPU's enable/byte-write-enable/address/write-data request, performs byte-lane writes or full-word reads on an internal word array, and returns read data on the following cycle. A configurable wait-state count exercises the pipeline's stall path through `stallreq`.

## Interface
- ADDR_W, 12, word-address width; array depth 2^ADDR_W 32-bit words
- WAIT_CYC, 0, extra wait cycles per access, legal range 0..15
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset rst, synchronous, active-high
- data_sram_en  in  1  access request
- data_sram_wen  in  4  byte write enables; bit i writes byte lane i (bits 8i+7:8i); 0 = read
- data_sram_addr  in  32  byte address
- data_sram_wdata  in  32  write data, lane-aligned by requester
- data_sram_rdata  out  32  registered read word
- stallreq  out  1  pipeline stall request while an access is waiting

## Operation
- Word index is data_sram_addr[ADDR_W+1:2].
  - addr[1:0] is ignored; byte/half selection is the MEM stage's job.
  - Upper address bits are ignored, so addresses wrap modulo 2^(ADDR_W+2).
  - No alignment or range errors are raised.
- Write (en=1, wen!=0): only lanes with wen[i]=1 are updated; other lanes are preserved. data_sram_rdata holds its previous value.
- Read (en=1, wen=0): the full word at the index is latched into data_sram_rdata.
- Idle (en=0): no array change; data_sram_rdata holds.
- State machine with states IDLE, WAIT, DONE and a 4-bit counter cnt:
  - WAIT_CYC=0: always IDLE. Each request commits at the edge ending its cycle; stallreq is constant 0.
  - IDLE: en=1 and WAIT_CYC>0 → go to WAIT and load cnt=WAIT_CYC-1. stallreq=1 combinationally in this cycle. Nothing commits.
  - WAIT: stallreq=1. If cnt=0, go to DONE; otherwise decrement cnt.
  - DONE: stallreq=0. The access commits at the edge ending DONE. Next state is IDLE unconditionally.
  - A request present in the first IDLE cycle after DONE starts a new access.
- The requester holds en/wen/addr/wdata stable while stallreq=1 and through DONE. Values sampled at commit are used.
- If en drops during WAIT, the access is abandoned: go to IDLE, no commit, stallreq=0 from that cycle.
- Array contents are not initialised by reset. The bench preloads through hierarchical access or writes.

## Timing
- Reset values: data_sram_rdata=0, stallreq=0, state=IDLE, cnt=0. The array is not cleared.
- rst asserted in any state, including mid-WAIT, aborts the pending access with no array write. The outputs take their reset values on the next edge.
- WAIT_CYC=0:
  - Request in cycle t → commit at the end of t.
  - A read's data is valid on data_sram_rdata throughout cycle t+1.
- WAIT_CYC=N>0:
  - Request first seen in IDLE at cycle t → stallreq=1 for cycles t..t+N.
  - DONE is cycle t+N+1, with stallreq=0. Commit at the end of t+N+1.
  - Read data is valid in t+N+2.
  - Total added stall = N+1 cycles.
- Write at cycle t followed by a read of the same word at t+1 returns the merged new word at t+2. There is no bypass hazard, because the write has already committed.
- Back-to-back reads with WAIT_CYC=0: rdata updates every cycle, each value valid for exactly one cycle after its request.
- stallreq depends combinationally on state and data_sram_en only, never on data_sram_rdata.

## Test plan
- Reset: assert rst for 2 cycles with en=1 and wen=4'hF → rdata=0, stallreq=0, and no word changed.
- WAIT_CYC=0 full write then read:
  - Write 0xDEADBEEF to 0x100 in cycle t, read 0x100 in cycle t+1 → rdata=0xDEADBEEF in t+2, stallreq never 1.
- Byte lanes:
  - Preload 0x11223344 at 0x20; write wen=4'b0100 with wdata=0x00AA0000 → read returns 0x11AA3344.
  - Then write wen=4'b0011 with wdata=0x0000BBCC → read returns 0x11AABBCC.
  - Read at 0x22 returns the same word as 0x20.
- Wrap and ignore: with ADDR_W=12, write 0x5 at 0x4000 → read at 0x0000 returns 0x5.
- WAIT_CYC=3 read:
  - Request at t → stallreq high t..t+3, low at t+4; rdata valid at t+5.
  - rdata keeps its old value during t..t+4.
- Abort cases with WAIT_CYC=3:
  - Drop en during WAIT → no write, stallreq low the same cycle.
  - Assert rst at t+2 of a write → the word is unchanged and state returns to IDLE.

Source files
------------

// File: rtl/data_sram_resp.sv
// Data-side synchronous SRAM responder: byte-lane writes, registered full-word reads,
// with an optional wait-state sequence that raises stallreq toward the pipeline.
module data_sram_resp #(
    parameter int unsigned ADDR_W   = 12,
    parameter int unsigned WAIT_CYC = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        data_sram_en,
    input  logic [3:0]  data_sram_wen,
    input  logic [31:0] data_sram_addr,
    input  logic [31:0] data_sram_wdata,
    output logic [31:0] data_sram_rdata,
    output logic        stallreq
);

    localparam int unsigned DEPTH    = 2 ** ADDR_W;
    localparam logic [3:0]  CNT_LOAD = 4'(WAIT_CYC - 1);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DONE
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [3:0]        cnt;
    logic [3:0]        cnt_nxt;
    logic              commit;
    logic [ADDR_W-1:0] idx;
    logic [31:0]       mem [DEPTH];

    // Byte offset and bits above the array are don't-care; the address simply wraps.
    assign idx = data_sram_addr[ADDR_W+1:2];

    logic unused_addr_bits;
    assign unused_addr_bits = ^{data_sram_addr[31:ADDR_W+2], data_sram_addr[1:0]};

    // Next-state, counter and stall/commit decode
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        stallreq  = 1'b0;
        commit    = 1'b0;
        if (WAIT_CYC == 0) begin
            state_nxt = IDLE;
            commit    = data_sram_en;
        end else begin
            case (state)
                IDLE: begin
                    if (data_sram_en) begin
                        stallreq  = 1'b1;
                        state_nxt = WAIT;
                        cnt_nxt   = CNT_LOAD;
                    end
                end
                WAIT: begin
                    if (!data_sram_en) begin
                        // Requester withdrew: abandon without touching the array
                        state_nxt = IDLE;
                        cnt_nxt   = 4'd0;
                    end else begin
                        stallreq = 1'b1;
                        if (cnt == 4'd0) begin
                            state_nxt = DONE;
                        end else begin
                            cnt_nxt = cnt - 4'd1;
                        end
                    end
                end
                DONE: begin
                    commit    = 1'b1;
                    state_nxt = IDLE;
                    cnt_nxt   = 4'd0;
                end
                default: begin
                    state_nxt = IDLE;
                    cnt_nxt   = 4'd0;
                end
            endcase
        end
    end

    // State, counter and read-data registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            cnt             <= 4'd0;
            data_sram_rdata <= 32'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (commit && (data_sram_wen == 4'd0)) begin
                data_sram_rdata <= mem[idx];
            end
        end
    end

    // Word array with per-lane write enables; not cleared by reset
    always_ff @(posedge clk) begin
        if (!rst && commit) begin
            for (int i = 0; i < 4; i++) begin
                if (data_sram_wen[i]) begin
                    mem[idx][8*i +: 8] <= data_sram_wdata[8*i +: 8];
                end
            end
        end
    end

endmodule
